// File: rtl/jt51_csr_ch_pkg.sv
// rtl/jt51_csr_ch_pkg.sv - shared constants and types for the channel-register write front end
package jt51_csr_ch_pkg;

   localparam logic [7:0] CH_BASE_DEFAULT = 8'h20;
   localparam int         NCH             = 8;

   typedef enum logic [1:0] {
      GRP_RLFBCON = 2'd0,
      GRP_KC      = 2'd1,
      GRP_KF      = 2'd2,
      GRP_AMSPMS  = 2'd3
   } grp_t;

   // Bit order matches the field packing of the channel register store
   localparam int STB_RL  = 0;
   localparam int STB_FB  = 1;
   localparam int STB_CON = 2;
   localparam int STB_KC  = 3;
   localparam int STB_KF  = 4;
   localparam int STB_AMS = 5;
   localparam int STB_PMS = 6;
   localparam int NSTB    = 7;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   function automatic logic [NSTB-1:0] grp_mask(input logic [1:0] g);
      logic [NSTB-1:0] m;
      m = '0;
      case (g)
         GRP_RLFBCON: begin
            m[STB_RL]  = 1'b1;
            m[STB_FB]  = 1'b1;
            m[STB_CON] = 1'b1;
         end
         GRP_KC:  m[STB_KC] = 1'b1;
         GRP_KF:  m[STB_KF] = 1'b1;
         default: begin
            m[STB_AMS] = 1'b1;
            m[STB_PMS] = 1'b1;
         end
      endcase
      return m;
   endfunction

endpackage

// File: rtl/jt51_csr_ch_dec.sv
// rtl/jt51_csr_ch_dec.sv - channel-register address decode and group-to-strobe mask
module jt51_csr_ch_dec
   import jt51_csr_ch_pkg::*;
#(
   parameter logic [7:0] CH_BASE = CH_BASE_DEFAULT
) (
   input  logic [7:0] addr,
   input  logic [1:0] grp_sel,
   output logic       in_range,
   output logic [2:0] ch,
   output logic [1:0] grp,
   output logic [6:0] mask
);

   logic [7:0] off;

   // Addresses below the base wrap to large offsets and fall out of range
   assign off      = addr - CH_BASE;
   assign in_range = (off[7:5] == 3'b000);
   assign ch       = off[2:0];
   assign grp      = off[4:3];
   assign mask     = grp_mask(grp_sel);

endmodule

// File: rtl/jt51_csr_ch_wr.sv
// rtl/jt51_csr_ch_wr.sv - holds a CPU channel-register write until its rotating slot comes round
module jt51_csr_ch_wr
   import jt51_csr_ch_pkg::*;
#(
   parameter logic [7:0] CH_BASE = CH_BASE_DEFAULT
) (
   input  logic       rst,
   input  logic       clk,
   input  logic       cen,
   input  logic       zero,
   input  logic       wr_valid,
   input  logic [7:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic       wr_ready,
   output logic       busy,
   output logic       overrun,
   output logic [2:0] slot,
   output logic [7:0] dout,
   output logic       up_rl_ch,
   output logic       up_fb_ch,
   output logic       up_con_ch,
   output logic       up_kc_ch,
   output logic       up_kf_ch,
   output logic       up_ams_ch,
   output logic       up_pms_ch
);

   state_t     state, state_nxt;
   logic [2:0] ch_q;
   logic [1:0] grp_q;
   logic       dec_in_range;
   logic [2:0] dec_ch;
   logic [1:0] dec_grp;
   logic [6:0] mask;
   logic       accept;
   logic       latch;
   logic       fire;
   logic [6:0] stb;

   jt51_csr_ch_dec #(.CH_BASE(CH_BASE)) u_dec (
      .addr     (wr_addr),
      .grp_sel  (grp_q),
      .in_range (dec_in_range),
      .ch       (dec_ch),
      .grp      (dec_grp),
      .mask     (mask)
   );

   assign busy     = (state == ST_WAIT);
   assign wr_ready = ~busy;
   assign accept   = wr_valid & wr_ready;
   assign latch    = accept & dec_in_range;
   assign fire     = busy & cen & (slot == ch_q);
   assign stb      = fire ? mask : '0;

   assign up_rl_ch  = stb[STB_RL];
   assign up_fb_ch  = stb[STB_FB];
   assign up_con_ch = stb[STB_CON];
   assign up_kc_ch  = stb[STB_KC];
   assign up_kf_ch  = stb[STB_KF];
   assign up_ams_ch = stb[STB_AMS];
   assign up_pms_ch = stb[STB_PMS];

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (latch) state_nxt = ST_WAIT;
         ST_WAIT: if (fire)  state_nxt = ST_IDLE;
         default:            state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot <= 3'd0;
      end else if (cen) begin
         if (zero || slot == 3'(NCH - 1)) slot <= 3'd0;
         else                             slot <= slot + 3'd1;
      end
   end

   // Out-of-range writes complete the handshake but leave the held write untouched
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ch_q  <= 3'd0;
         grp_q <= 2'd0;
         dout  <= 8'd0;
      end else if (latch) begin
         ch_q  <= dec_ch;
         grp_q <= dec_grp;
         dout  <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun <= 1'b0;
      end else begin
         overrun <= wr_valid & busy;
      end
   end

endmodule

// File: tb/tb_jt51_csr_ch_wr.sv
// tb/tb_jt51_csr_ch_wr.sv - directed bench for the channel-register write front end
module tb_jt51_csr_ch_wr;

   logic       rst = 1'b1;
   logic       clk = 1'b0;
   logic       cen = 1'b0;
   logic       zero = 1'b0;
   logic       wr_valid = 1'b0;
   logic [7:0] wr_addr = 8'd0;
   logic [7:0] wr_data = 8'd0;
   logic       wr_ready, busy, overrun;
   logic [2:0] slot;
   logic [7:0] dout;
   logic       up_rl_ch, up_fb_ch, up_con_ch, up_kc_ch, up_kf_ch, up_ams_ch, up_pms_ch;
   logic [6:0] up;

   int tests = 0;
   int fails = 0;
   int ph = 0;
   int cen_div = 1;
   int cnt [7];
   int fire_slot, fire_idx, busy_clks, ov_clks, cen_count, nocen_fire, fire_steps;
   logic last_ready;
   int acc_idx;

   jt51_csr_ch_wr dut (
      .rst       (rst),
      .clk       (clk),
      .cen       (cen),
      .zero      (zero),
      .wr_valid  (wr_valid),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_ready  (wr_ready),
      .busy      (busy),
      .overrun   (overrun),
      .slot      (slot),
      .dout      (dout),
      .up_rl_ch  (up_rl_ch),
      .up_fb_ch  (up_fb_ch),
      .up_con_ch (up_con_ch),
      .up_kc_ch  (up_kc_ch),
      .up_kf_ch  (up_kf_ch),
      .up_ams_ch (up_ams_ch),
      .up_pms_ch (up_pms_ch)
   );

   assign up = {up_pms_ch, up_ams_ch, up_kf_ch, up_kc_ch, up_con_ch, up_fb_ch, up_rl_ch};

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      for (int i = 0; i < 7; i++) cnt[i] = 0;
      fire_slot = -1;
      fire_idx = -1;
      busy_clks = 0;
      ov_clks = 0;
      nocen_fire = 0;
      fire_steps = 0;
   endtask

   function automatic int total_stb();
      int s;
      s = 0;
      for (int i = 0; i < 7; i++) s += cnt[i];
      return s;
   endfunction

   // Called at a negedge: set cen, sample pre-edge outputs, advance one clk
   task automatic step();
      cen = ((ph % cen_div) == 0);
      ph++;
      #1;
      last_ready = wr_ready;
      if (up != 7'd0) begin
         for (int i = 0; i < 7; i++) if (up[i]) cnt[i]++;
         fire_slot = int'(slot);
         fire_idx = cen_count;
         fire_steps++;
         if (!cen) nocen_fire++;
      end
      if (busy) busy_clks++;
      if (overrun) ov_clks++;
      if (cen) cen_count++;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_slot(input logic [2:0] s);
      int n;
      n = 0;
      while (!(slot == s && (ph % cen_div) == 0) && n < 100) begin
         step();
         n++;
      end
      if (n >= 100) check("wait_slot_timeout", 32'(n), 32'd0);
   endtask

   task automatic do_write(input logic [7:0] a, input logic [7:0] d);
      wr_valid = 1'b1;
      wr_addr = a;
      wr_data = d;
      acc_idx = cen_count;
      step();
      wr_valid = 1'b0;
   endtask

   task automatic run_idle(input int max);
      int n;
      n = 0;
      while (busy && n < max) begin
         step();
         n++;
      end
      if (busy) check("run_idle_timeout", 32'(busy), 32'd0);
   endtask

   initial begin
      clear_mon();
      cen_count = 0;
      repeat (3) @(negedge clk);
      check("rst_slot", 32'(slot), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(wr_ready), 32'd1);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_dout", 32'(dout), 32'd0);
      check("rst_up", 32'(up), 32'd0);
      rst = 1'b0;

      // 1: resync with zero at slot 7, write 0x2B (grp1 ch3) at slot 1
      wait_slot(3'd7);
      zero = 1'b1;
      step();
      zero = 1'b0;
      check("t1_zero_slot", 32'(slot), 32'd0);
      wait_slot(3'd1);
      clear_mon();
      do_write(8'h2B, 8'hC5);
      check("t1_ready", 32'(last_ready), 32'd1);
      repeat (10) step();
      check("t1_kc_cnt", 32'(cnt[3]), 32'd1);
      check("t1_total", 32'(total_stb()), 32'd1);
      check("t1_fire_slot", 32'(fire_slot), 32'd3);
      check("t1_latency", 32'(fire_idx - acc_idx), 32'd2);
      check("t1_busy_cens", 32'(busy_clks), 32'd2);
      check("t1_dout", 32'(dout), 32'hC5);

      // 2: write 0x2D (grp1 ch5) at slot 5 -> a full rotation
      wait_slot(3'd5);
      clear_mon();
      do_write(8'h2D, 8'h4A);
      run_idle(20);
      check("t2_kc_cnt", 32'(cnt[3]), 32'd1);
      check("t2_total", 32'(total_stb()), 32'd1);
      check("t2_fire_slot", 32'(fire_slot), 32'd5);
      check("t2_latency", 32'(fire_idx - acc_idx), 32'd8);
      check("t2_dout", 32'(dout), 32'h4A);

      // 3: cen every 4th clk, write 0x30 (grp2 ch0) at slot 7
      cen_div = 4;
      wait_slot(3'd7);
      clear_mon();
      do_write(8'h30, 8'hFC);
      run_idle(40);
      repeat (8) step();
      check("t3_kf_cnt", 32'(cnt[4]), 32'd1);
      check("t3_total", 32'(total_stb()), 32'd1);
      check("t3_fire_slot", 32'(fire_slot), 32'd0);
      check("t3_nocen_fire", 32'(nocen_fire), 32'd0);
      check("t3_busy_clks", 32'(busy_clks), 32'd4);
      check("t3_dout", 32'(dout), 32'hFC);
      cen_div = 1;

      // 4: write 0x3F (grp3 ch7), then a refused write one clk later
      wait_slot(3'd2);
      clear_mon();
      do_write(8'h3F, 8'h73);
      do_write(8'h21, 8'h99);
      check("t4_second_ready", 32'(last_ready), 32'd0);
      run_idle(20);
      check("t4_ams_cnt", 32'(cnt[5]), 32'd1);
      check("t4_pms_cnt", 32'(cnt[6]), 32'd1);
      check("t4_total", 32'(total_stb()), 32'd2);
      check("t4_fire_steps", 32'(fire_steps), 32'd1);
      check("t4_fire_slot", 32'(fire_slot), 32'd7);
      check("t4_overrun_clks", 32'(ov_clks), 32'd1);
      check("t4_dout", 32'(dout), 32'h73);
      clear_mon();
      do_write(8'h21, 8'h99);
      check("t4_retry_ready", 32'(last_ready), 32'd1);
      run_idle(20);
      check("t4_retry_rl", 32'(cnt[0]), 32'd1);
      check("t4_retry_fb", 32'(cnt[1]), 32'd1);
      check("t4_retry_con", 32'(cnt[2]), 32'd1);
      check("t4_retry_total", 32'(total_stb()), 32'd3);
      check("t4_retry_slot", 32'(fire_slot), 32'd1);
      check("t4_retry_dout", 32'(dout), 32'h99);

      // 5: out-of-range addresses handshake and do nothing
      step();
      clear_mon();
      do_write(8'h1F, 8'hAA);
      check("t5_ready_1f", 32'(last_ready), 32'd1);
      do_write(8'h40, 8'hBB);
      check("t5_ready_40", 32'(last_ready), 32'd1);
      do_write(8'h08, 8'hCC);
      check("t5_ready_08", 32'(last_ready), 32'd1);
      repeat (16) step();
      check("t5_total", 32'(total_stb()), 32'd0);
      check("t5_busy_clks", 32'(busy_clks), 32'd0);
      check("t5_dout", 32'(dout), 32'h99);

      // 6: reset while 0x22 (grp0 ch2) is pending
      wait_slot(3'd7);
      clear_mon();
      do_write(8'h22, 8'h11);
      step();
      check("t6_busy_before_rst", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("t6_rst_slot", 32'(slot), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_dout", 32'(dout), 32'd0);
      check("t6_rst_up", 32'(up), 32'd0);
      check("t6_rst_overrun", 32'(overrun), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (16) step();
      check("t6_no_stb", 32'(total_stb()), 32'd0);
      wait_slot(3'd4);
      clear_mon();
      do_write(8'h27, 8'h5A);
      run_idle(20);
      check("t6_next_rl", 32'(cnt[0]), 32'd1);
      check("t6_next_total", 32'(total_stb()), 32'd3);
      check("t6_next_slot", 32'(fire_slot), 32'd7);
      check("t6_next_latency", 32'(fire_idx - acc_idx), 32'd3);
      check("t6_next_dout", 32'(dout), 32'h5A);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
